// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  localparam int unsigned WDOG_W        = 10;
  // Largest supported DRAIN_CYC; the drain count runs 0..DRAIN_CYC-1.
  localparam int unsigned DRAIN_CYC_MAX = 256;
  localparam int unsigned DRAIN_W       = $clog2(DRAIN_CYC_MAX);

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, memory-busy and branch-flush events into
// per-stage enables, with debug drain/halt, a memory-stall watchdog and perf counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lu_hazard_i,
  input  logic             mem_busy_i,
  input  logic             branch_flush_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_noop_o,
  output logic             pipe_write_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e              state_q, state_d;
  logic [WDOG_W-1:0]   wd_q, wd_d;
  logic [DRAIN_W-1:0]  dcnt_q, dcnt_d;
  logic                lu_inc, mem_inc, flush_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Priority: reset > ERROR > memory freeze > per-state action.
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    dcnt_d       = dcnt_q;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_noop_o  = 1'b1;
    pipe_write_o = 1'b0;
    lu_inc       = 1'b0;
    mem_inc      = 1'b0;
    flush_inc    = 1'b0;

    if (rst_i || (state_q == ST_ERROR)) begin
      // hold: bubble, no writes
    end else if (mem_busy_i) begin
      idex_noop_o = 1'b0;
      mem_inc     = 1'b1;
      wd_d        = wd_q + WDOG_W'(1);
      if (wd_q == WDOG_W'(TIMEOUT - 1)) begin
        state_d = ST_ERROR;
      end
    end else begin
      wd_d = '0;
      case (state_q)
        ST_RUN: begin
          pipe_write_o = 1'b1;
          if (lu_hazard_i) begin
            lu_inc = 1'b1;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            idex_noop_o  = 1'b0;
            if (branch_flush_i) begin
              ifid_flush_o = 1'b1;
              flush_inc    = 1'b1;
            end
          end
          if (halt_req_i) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end
        ST_DRAIN: begin
          pipe_write_o = 1'b1;
          if (dcnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
            state_d = ST_HALTED;
          end else begin
            dcnt_d = dcnt_q + DRAIN_W'(1);
          end
        end
        ST_HALTED: begin
          pipe_write_o = 1'b1;
          if (resume_i) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign halted_o = !rst_i && (state_q == ST_HALTED);
  assign err_o    = !rst_i && (state_q == ST_ERROR);

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (lu_inc),
    .cnt_o (lu_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (mem_inc),
    .cnt_o (mem_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl; a second instance with 4-bit counters checks saturation.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst, lu, busy, br, halt, resume;

  logic        pc_w, ifid_w, ifid_f, noop, pipe_w, halted, err;
  logic [31:0] lu_cnt, mem_cnt, fl_cnt;
  logic        s_pc_w, s_ifid_w, s_ifid_f, s_noop, s_pipe_w, s_halted, s_err;
  logic [3:0]  s_lu_cnt, s_mem_cnt, s_fl_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TIMEOUT(64), .DRAIN_CYC(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .lu_hazard_i(lu), .mem_busy_i(busy),
    .branch_flush_i(br), .halt_req_i(halt), .resume_i(resume),
    .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f),
    .idex_noop_o(noop), .pipe_write_o(pipe_w), .halted_o(halted), .err_o(err),
    .lu_cnt_o(lu_cnt), .mem_cnt_o(mem_cnt), .flush_cnt_o(fl_cnt)
  );

  pipeline_stall_ctrl #(.TIMEOUT(64), .DRAIN_CYC(4), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .lu_hazard_i(lu), .mem_busy_i(busy),
    .branch_flush_i(br), .halt_req_i(halt), .resume_i(resume),
    .pc_write_o(s_pc_w), .ifid_write_o(s_ifid_w), .ifid_flush_o(s_ifid_f),
    .idex_noop_o(s_noop), .pipe_write_o(s_pipe_w), .halted_o(s_halted), .err_o(s_err),
    .lu_cnt_o(s_lu_cnt), .mem_cnt_o(s_mem_cnt), .flush_cnt_o(s_fl_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lu = 1'b0; busy = 1'b0; br = 1'b0; halt = 1'b0; resume = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (pc_w !== 1'b0) begin failed++; $display("FAIL reset_pc_write got %0b exp 0", pc_w); end
    tests++; if (noop !== 1'b1) begin failed++; $display("FAIL reset_noop got %0b exp 1", noop); end
    tests++; if (err !== 1'b0 || halted !== 1'b0) begin failed++; $display("FAIL reset_flags got err=%0b halted=%0b exp 0/0", err, halted); end
    tests++; if (lu_cnt !== 32'd0 || mem_cnt !== 32'd0 || fl_cnt !== 32'd0) begin
      failed++; $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", lu_cnt, mem_cnt, fl_cnt); end
    rst = 1'b0;
    #1;
    tests++; if ({pc_w, ifid_w, pipe_w, noop, ifid_f} !== 5'b11100) begin
      failed++; $display("FAIL run_idle_outputs got %b exp 11100", {pc_w, ifid_w, pipe_w, noop, ifid_f}); end
  endtask

  task automatic test_lu_branch();
    lu = 1'b1; br = 1'b1;
    #1;
    tests++; if ({pc_w, ifid_w, pipe_w, noop, ifid_f} !== 5'b00110) begin
      failed++; $display("FAIL lu_branch_outputs got %b exp 00110", {pc_w, ifid_w, pipe_w, noop, ifid_f}); end
    tick();
    lu = 1'b0;
    #1;
    tests++; if (lu_cnt !== 32'd1 || fl_cnt !== 32'd0) begin
      failed++; $display("FAIL lu_branch_counts got lu=%0d fl=%0d exp 1/0", lu_cnt, fl_cnt); end
    tests++; if ({pc_w, ifid_w, pipe_w, noop, ifid_f} !== 5'b11101) begin
      failed++; $display("FAIL branch_outputs got %b exp 11101", {pc_w, ifid_w, pipe_w, noop, ifid_f}); end
    tick();
    br = 1'b0;
    #1;
    tests++; if (fl_cnt !== 32'd1) begin failed++; $display("FAIL branch_count got %0d exp 1", fl_cnt); end
  endtask

  task automatic test_mem_freeze();
    int bad;
    do_reset();
    bad = 0;
    busy = 1'b1;
    for (int i = 0; i < 63; i++) begin
      #1;
      if ({pc_w, ifid_w, pipe_w, noop, ifid_f, err} !== 6'b0) bad++;
      tick();
    end
    tests++; if (bad !== 0) begin failed++; $display("FAIL freeze_outputs got %0d bad cycles exp 0", bad); end
    busy = 1'b0;
    #1;
    tests++; if (err !== 1'b0 || pc_w !== 1'b1) begin
      failed++; $display("FAIL freeze63_resume got err=%0b pc=%0b exp 0/1", err, pc_w); end
    tests++; if (mem_cnt !== 32'd63) begin failed++; $display("FAIL freeze63_count got %0d exp 63", mem_cnt); end
    tick();
    busy = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    busy = 1'b0;
    #1;
    tests++; if (err !== 1'b1 || pc_w !== 1'b0 || noop !== 1'b1) begin
      failed++; $display("FAIL watchdog_trip got err=%0b pc=%0b noop=%0b exp 1/0/1", err, pc_w, noop); end
    busy = 1'b1; lu = 1'b1; resume = 1'b1;
    tick(); tick(); tick();
    idle();
    #1;
    tests++; if (err !== 1'b1 || mem_cnt !== 32'd127 || lu_cnt !== 32'd0) begin
      failed++; $display("FAIL error_hold got err=%0b mem=%0d lu=%0d exp 1/127/0", err, mem_cnt, lu_cnt); end
    do_reset();
    #1;
    tests++; if (err !== 1'b0 || pc_w !== 1'b1 || mem_cnt !== 32'd0) begin
      failed++; $display("FAIL error_reset got err=%0b pc=%0b mem=%0d exp 0/1/0", err, pc_w, mem_cnt); end
  endtask

  task automatic test_drain();
    int first;
    do_reset();
    halt = 1'b1;
    #1;
    tests++; if (pc_w !== 1'b1 || halted !== 1'b0) begin
      failed++; $display("FAIL halt_req_cycle got pc=%0b halted=%0b exp 1/0", pc_w, halted); end
    tick();
    halt = 1'b0;
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      busy = (c == 3 || c == 4);
      br   = (c == 1);
      lu   = (c == 2);
      #1;
      if (c == 1) begin
        tests++; if ({pc_w, ifid_w, pipe_w, noop, ifid_f} !== 5'b00110) begin
          failed++; $display("FAIL drain_outputs got %b exp 00110", {pc_w, ifid_w, pipe_w, noop, ifid_f}); end
      end
      if (c == 3) begin
        tests++; if ({pc_w, ifid_w, pipe_w, noop, ifid_f} !== 5'b00000) begin
          failed++; $display("FAIL drain_freeze got %b exp 00000", {pc_w, ifid_w, pipe_w, noop, ifid_f}); end
      end
      if (halted === 1'b1) begin
        first = c;
        break;
      end
      tick();
    end
    idle();
    tests++; if (first !== 7) begin failed++; $display("FAIL halt_latency got %0d exp 7", first); end
    tests++; if (fl_cnt !== 32'd0 || lu_cnt !== 32'd0 || mem_cnt !== 32'd2) begin
      failed++; $display("FAIL drain_counts got fl=%0d lu=%0d mem=%0d exp 0/0/2", fl_cnt, lu_cnt, mem_cnt); end
    resume = 1'b1;
    #1;
    tests++; if (pc_w !== 1'b0 || noop !== 1'b1 || halted !== 1'b1) begin
      failed++; $display("FAIL halted_outputs got pc=%0b noop=%0b halted=%0b exp 0/1/1", pc_w, noop, halted); end
    tick();
    resume = 1'b0;
    #1;
    tests++; if (pc_w !== 1'b1 || halted !== 1'b0) begin
      failed++; $display("FAIL resume got pc=%0b halted=%0b exp 1/0", pc_w, halted); end
  endtask

  task automatic test_saturation();
    do_reset();
    lu = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    lu = 1'b0;
    #1;
    tests++; if (s_lu_cnt !== 4'd15) begin failed++; $display("FAIL sat_lu_cnt got %0d exp 15", s_lu_cnt); end
    tests++; if (lu_cnt !== 32'd20) begin failed++; $display("FAIL wide_lu_cnt got %0d exp 20", lu_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    lu = 1'b1;
    tick(); tick(); tick();
    lu = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick(); tick();
    #1;
    tests++; if (pc_w !== 1'b0 || lu_cnt !== 32'd3) begin
      failed++; $display("FAIL pre_reset_drain got pc=%0b lu=%0d exp 0/3", pc_w, lu_cnt); end
    rst = 1'b1;
    #1;
    tests++; if (halted !== 1'b0 || pc_w !== 1'b0 || noop !== 1'b1) begin
      failed++; $display("FAIL mid_drain_reset got halted=%0b pc=%0b noop=%0b exp 0/0/1", halted, pc_w, noop); end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (pc_w !== 1'b1 || halted !== 1'b0 || lu_cnt !== 32'd0) begin
      failed++; $display("FAIL after_reset_run got pc=%0b halted=%0b lu=%0d exp 1/0/0", pc_w, halted, lu_cnt); end
    tick(); tick(); tick(); tick();
    #1;
    tests++; if (pc_w !== 1'b1 || halted !== 1'b0) begin
      failed++; $display("FAIL no_partial_drain got pc=%0b halted=%0b exp 1/0", pc_w, halted); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_lu_branch();
    test_mem_freeze();
    test_drain();
    test_saturation();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
